// File: rtl/float_pkg.sv
// Shared float constants, result class bundle and classifier
// used by the float adder result-side collector.
package float_pkg;

    localparam int FLOAT_W = 32;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int SEQ_W   = 8;
    localparam int FLAG_W  = 4;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic sign;
    } float_class_t;

    // Denormals keep zero=0: only an all-zero exponent and mantissa counts.
    function automatic float_class_t classify_float(
        input logic [FLOAT_W-1:0] f
    );
        float_class_t c;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        e      = f[FLOAT_W-2 -: EXP_W];
        m      = f[MANT_W-1:0];
        c.nan  = (e == EXP_ALL_ONES) && (m != '0);
        c.inf  = (e == EXP_ALL_ONES) && (m == '0);
        c.zero = (e == '0) && (m == '0);
        c.sign = f[FLOAT_W-1];
        return c;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO holding adder results with
// their class flags and sequence tag.
module result_fifo #(
    parameter int DW    = 44,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign count_o = count_q;
    assign rdata_o = (count_q != '0) ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/float_sum_collector.sv
// Result-side endpoint of the pipelined float adder: captures sums,
// classifies them, and grants credit-based issue permission.
module float_sum_collector
    import float_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int PIPE_STAGES = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_i,
    input  logic                     sum_valid_i,
    input  logic [WIDTH-1:0]         sum_i,
    output logic                     can_issue_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [WIDTH-1:0]         res_data_o,
    output logic [3:0]               res_flags_o,
    output logic [7:0]               res_seq_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH + PIPE_STAGES + 1);
    localparam int EW = WIDTH + FLAG_W + SEQ_W;

    logic [IW-1:0]    inflight_q;
    logic [SEQ_W-1:0] seq_q;
    logic             ovf_q;
    logic             unf_q;

    logic [CW-1:0]    count;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    rd_entry;
    float_class_t     cls;
    logic             full;
    logic             pop;
    logic             push;

    assign cls      = classify_float(FLOAT_W'(sum_i));
    assign full     = (count == CW'(DEPTH));
    assign pop      = res_valid_o && res_ready_i;
    // A full FIFO still takes a result if the head leaves this cycle.
    assign push     = sum_valid_i && (!full || pop);
    assign wr_entry = {sum_i, cls, seq_q};

    result_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .count_o (count)
    );

    assign res_valid_o = (count != '0);
    assign res_data_o  = rd_entry[EW-1 -: WIDTH];
    assign res_flags_o = rd_entry[SEQ_W +: FLAG_W];
    assign res_seq_o   = rd_entry[SEQ_W-1:0];
    assign count_o     = count;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    // Credit check uses registered state only, never issue_i.
    assign can_issue_o = (32'(count) + 32'(inflight_q)) < 32'(DEPTH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            unf_q      <= 1'b0;
        end else begin
            unique case ({issue_i, sum_valid_i})
                2'b10: inflight_q <= inflight_q + IW'(1);
                2'b01: begin
                    if (inflight_q == '0) begin
                        unf_q <= 1'b1;
                    end else begin
                        inflight_q <= inflight_q - IW'(1);
                    end
                end
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (sum_valid_i && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule
